regfile_wb_sched: RTL



---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_wb_sched_if.sv | 69 ++++++
 rtl/wb_scoreboard.sv | 82 ++++++++
 rtl/regfile_wb_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Optional bypass outputs are enabled with the WB_BYPASS_EN macro.
package regfile_pkg;

    localparam int REG_W    = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    localparam logic [ADDR_W-1:0] PAIR_REG_DEF = 4'd15;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        REQ_MEM,
        REQ_MDU,
        REQ_ALU,
        REQ_NONE
    } req_e;

    typedef enum logic {
        ST_IDLE,
        ST_MDU_HI
    } state_e;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bundle of requester handshakes, decode lookups and write-port outputs.
// Bypass signals exist only when WB_BYPASS_EN is defined.
interface regfile_wb_sched_if;
    import regfile_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dest;
    logic [REG_W-1:0]  mem_data;

    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_dest;
    logic [REG_W-1:0]  mdu_lo;
    logic [REG_W-1:0]  mdu_hi;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [REG_W-1:0]  alu_data;

    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_dest;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic              hazard_1;
    logic              hazard_2;

    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_dest;
    logic [REG_W-1:0]  rf_wr_data;
    logic              busy;
    logic              sb_err;
`ifdef WB_BYPASS_EN
    logic              byp_hit_1;
    logic              byp_hit_2;
    logic [REG_W-1:0]  byp_data_1;
    logic [REG_W-1:0]  byp_data_2;
`endif

    modport master (
        output mem_valid, mem_dest, mem_data,
        output mdu_valid, mdu_dest, mdu_lo, mdu_hi,
        output alu_valid, alu_dest, alu_data,
        output rsv_en, rsv_dest, rd_addr_1, rd_addr_2,
        input  mem_ready, mdu_ready, alu_ready,
        input  hazard_1, hazard_2,
        input  rf_wr_en, rf_wr_dest, rf_wr_data,
`ifdef WB_BYPASS_EN
        input  byp_hit_1, byp_hit_2, byp_data_1, byp_data_2,
`endif
        input  busy, sb_err
    );

    modport slave (
        input  mem_valid, mem_dest, mem_data,
        input  mdu_valid, mdu_dest, mdu_lo, mdu_hi,
        input  alu_valid, alu_dest, alu_data,
        input  rsv_en, rsv_dest, rd_addr_1, rd_addr_2,
        output mem_ready, mdu_ready, alu_ready,
        output hazard_1, hazard_2,
        output rf_wr_en, rf_wr_dest, rf_wr_data,
`ifdef WB_BYPASS_EN
        output byp_hit_1, byp_hit_2, byp_data_1, byp_data_2,
`endif
        output busy, sb_err
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard with hazard lookups for both read ports.
// With WB_BYPASS_EN, an in-flight write forwards and masks the hazard.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_dest,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_dest,
`ifdef WB_BYPASS_EN
    input  logic [REG_W-1:0]  i_wr_data,
    output logic              o_byp_hit_1,
    output logic              o_byp_hit_2,
    output logic [REG_W-1:0]  o_byp_data_1,
    output logic [REG_W-1:0]  o_byp_data_2,
`endif
    input  logic [ADDR_W-1:0] i_rd_addr_1,
    input  logic [ADDR_W-1:0] i_rd_addr_2,
    output logic              o_hazard_1,
    output logic              o_hazard_2,
    output logic              o_sb_err
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic                w_rsv_ok;
    logic                r_err;
    logic                w_pend_1;
    logic                w_pend_2;

    assign w_rsv_ok = i_rsv_en && (i_rsv_dest != '0);

    // Decode set/clear masks; register 0 is never tracked
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_rsv_ok)
            w_set[i_rsv_dest] = 1'b1;
        if (i_wr_en && (i_wr_dest != '0))
            w_clr[i_wr_dest] = 1'b1;
    end

    // Pending vector and sticky double-reservation error; set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_rsv_ok && r_pending[i_rsv_dest])
                r_err <= 1'b1;
        end
    end

    assign w_pend_1 = r_pending[i_rd_addr_1];
    assign w_pend_2 = r_pending[i_rd_addr_2];
    assign o_sb_err = r_err;

`ifdef WB_BYPASS_EN
    logic w_hit_1;
    logic w_hit_2;

    assign w_hit_1 = i_wr_en && (i_wr_dest == i_rd_addr_1)
                     && (i_rd_addr_1 != '0);
    assign w_hit_2 = i_wr_en && (i_wr_dest == i_rd_addr_2)
                     && (i_rd_addr_2 != '0);

    assign o_byp_hit_1  = w_hit_1;
    assign o_byp_hit_2  = w_hit_2;
    assign o_byp_data_1 = i_wr_data;
    assign o_byp_data_2 = i_wr_data;
    assign o_hazard_1   = w_pend_1 && !w_hit_1;
    assign o_hazard_2   = w_pend_2 && !w_hit_2;
`else
    assign o_hazard_1 = w_pend_1;
    assign o_hazard_2 = w_pend_2;
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// Arbitrates memory, MDU and ALU results onto the single RF write port.
// WB_BYPASS_EN adds write-port forwarding outputs to the bus interface.
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PAIR_REG     = PAIR_REG_DEF,
    parameter int                STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sched_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    state_e            r_state;
    state_e            w_next;
    req_e              w_grant;
    logic [SW-1:0]     r_starve;
    logic              w_alu_first;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_dest;
    logic [REG_W-1:0]  r_wr_data;
    logic [REG_W-1:0]  r_hi;

    assign w_alu_first = bus.alu_valid && (r_starve == LIM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Grant selection, ready generation and next state
    always_comb begin
        w_next        = r_state;
        w_grant       = REQ_NONE;
        bus.mem_ready = 1'b0;
        bus.mdu_ready = 1'b0;
        bus.alu_ready = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_alu_first)
                    w_grant = REQ_ALU;
                else if (bus.mem_valid)
                    w_grant = REQ_MEM;
                else if (bus.mdu_valid)
                    w_grant = REQ_MDU;
                else if (bus.alu_valid)
                    w_grant = REQ_ALU;
                if (w_grant == REQ_MDU)
                    w_next = ST_MDU_HI;
            end
            ST_MDU_HI: begin
                w_next = ST_IDLE;
            end
        endcase
        bus.mem_ready = (w_grant == REQ_MEM);
        bus.mdu_ready = (w_grant == REQ_MDU);
        bus.alu_ready = (w_grant == REQ_ALU);
    end

    // ALU starvation counter, saturating, cleared on ALU accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_starve <= '0;
        else if (bus.alu_valid && bus.alu_ready)
            r_starve <= '0;
        else if (bus.alu_valid && (r_starve != LIM))
            r_starve <= r_starve + 1'b1;
    end

    // Registered write port; MDU high half follows in the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_dest <= '0;
            r_wr_data <= '0;
            r_hi      <= '0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (w_grant)
                REQ_MEM: begin
                    r_wr_en   <= (bus.mem_dest != '0);
                    r_wr_dest <= bus.mem_dest;
                    r_wr_data <= bus.mem_data;
                end
                REQ_MDU: begin
                    r_wr_en   <= (bus.mdu_dest != '0);
                    r_wr_dest <= bus.mdu_dest;
                    r_wr_data <= bus.mdu_lo;
                    r_hi      <= bus.mdu_hi;
                end
                REQ_ALU: begin
                    r_wr_en   <= (bus.alu_dest != '0);
                    r_wr_dest <= bus.alu_dest;
                    r_wr_data <= bus.alu_data;
                end
                REQ_NONE: begin
                    if (r_state == ST_MDU_HI) begin
                        r_wr_en   <= 1'b1;
                        r_wr_dest <= PAIR_REG;
                        r_wr_data <= r_hi;
                    end
                end
            endcase
        end
    end

    assign bus.rf_wr_en   = r_wr_en;
    assign bus.rf_wr_dest = r_wr_dest;
    assign bus.rf_wr_data = r_wr_data;
    assign bus.busy       = (r_state != ST_IDLE) | r_wr_en;

    wb_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_rsv_en     (bus.rsv_en),
        .i_rsv_dest   (bus.rsv_dest),
        .i_wr_en      (r_wr_en),
        .i_wr_dest    (r_wr_dest),
`ifdef WB_BYPASS_EN
        .i_wr_data    (r_wr_data),
        .o_byp_hit_1  (bus.byp_hit_1),
        .o_byp_hit_2  (bus.byp_hit_2),
        .o_byp_data_1 (bus.byp_data_1),
        .o_byp_data_2 (bus.byp_data_2),
`endif
        .i_rd_addr_1  (bus.rd_addr_1),
        .i_rd_addr_2  (bus.rd_addr_2),
        .o_hazard_1   (bus.hazard_1),
        .o_hazard_2   (bus.hazard_2),
        .o_sb_err     (bus.sb_err)
    );

endmodule
